// File: rtl/bus_arbiter_split_pkg.sv
// Shared types and constants for the split-capable bus arbiter: response codes,
// master ID space and FSM state encodings.
package bus_arbiter_split_pkg;

    localparam int ID_W        = 2;
    localparam int MAX_MASTERS = 3;

    localparam logic [ID_W-1:0] NO_MASTER = '0;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01,
        RESP_RETRY = 2'b10,
        RESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_LOCKED  = 2'd2
    } arb_state_e;

    // Master ID (1-based) to one-hot vector; ID 0 and out-of-range IDs give 0.
    function automatic logic [MAX_MASTERS-1:0] id_onehot(input logic [ID_W-1:0] id);
        logic [MAX_MASTERS-1:0] oh;
        oh = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (id == ID_W'(i + 1)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/bus_arbiter_split_if.sv
// Arbiter-side bus signals bundled for the masters' request lines and the slaves' response lines.
interface bus_arbiter_split_if #(
    parameter int NUM_MASTERS = 3
);
    import bus_arbiter_split_pkg::*;

    // Handshake: a master holds hbusreq until it sees its hgrant bit; the grant only moves
    // on an edge where hready is not 0, except a SPLIT response, which moves it at once.
    logic [NUM_MASTERS-1:0] hbusreq;
    logic [NUM_MASTERS-1:0] hlock;
    logic                   hready;
    logic [1:0]             hresp;
    logic [ID_W-1:0]        hsplit;

    logic [NUM_MASTERS-1:0] hgrant;
    logic [ID_W-1:0]        hmas;
    logic                   mlock;
    logic [NUM_MASTERS-1:0] split_mask;

    modport master (
        input  hbusreq, hlock, hready, hresp, hsplit,
        output hgrant, hmas, mlock, split_mask
    );

    modport slave (
        output hbusreq, hlock, hready, hresp, hsplit,
        input  hgrant, hmas, mlock, split_mask
    );

endinterface

// File: rtl/bus_arbiter_split_pick.sv
// Combinational picker: first eligible master at or after start_id, wrapping NUM_MASTERS -> 1.
module bus_arbiter_split_pick
    import bus_arbiter_split_pkg::*;
#(
    parameter int NUM_MASTERS = 3
) (
    input  logic [NUM_MASTERS-1:0] eligible,
    input  logic [ID_W-1:0]        start_id,
    output logic [ID_W-1:0]        winner,
    output logic                   valid
);

    logic [2*NUM_MASTERS-1:0] dbl;
    logic [NUM_MASTERS-1:0]   rot;
    int                       off;

    always_comb begin
        off = (start_id == NO_MASTER || int'(start_id) > NUM_MASTERS) ? 0 : int'(start_id) - 1;
        dbl = {eligible, eligible} >> off;
        rot = dbl[NUM_MASTERS-1:0];
        winner = NO_MASTER;
        valid  = 1'b0;
        // Walk downwards so the lowest rotated position is the last one written.
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid  = 1'b1;
                winner = ID_W'(((off + k) % NUM_MASTERS) + 1);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_split.sv
// Central bus arbiter with lock, tenure limit and SPLIT parking of masters.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise the lowest ID wins.
module bus_arbiter_split
    import bus_arbiter_split_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int MAX_TENURE  = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    bus_arbiter_split_if.master  bus,
    output arb_state_e           state_dbg
);

    localparam int              TW          = $clog2(MAX_TENURE + 1);
    localparam logic [TW-1:0]   TENURE_LAST = TW'(MAX_TENURE - 1);

    arb_state_e             state;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [ID_W-1:0]        mas_q;
    logic                   mlock_q;
    logic [NUM_MASTERS-1:0] mask_q;
    logic [TW-1:0]          tenure;

    logic                   ready;
    logic                   split_hit;
    logic                   resp_error;
    logic                   owner_req;
    logic                   owner_lock;
    logic                   others;
    logic                   rearb;
    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] set_mask;
    logic [NUM_MASTERS-1:0] clr_mask;
    logic [NUM_MASTERS-1:0] pick_elig;
    logic [NUM_MASTERS-1:0] win_oh;
    logic [MAX_MASTERS-1:0] clr_full;
    logic [MAX_MASTERS-1:0] win_full;
    logic [ID_W-1:0]        start_id;
    logic [ID_W-1:0]        pick_id;
    logic                   pick_valid;
    logic                   win_lock;
    logic                   do_grant;
    logic                   do_idle;
    logic                   do_unlock;

`ifdef ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0]        rr_ptr;
    assign start_id = rr_ptr;
`else
    assign start_id = ID_W'(1);
`endif

    // An undriven (pulled-up) hready counts as ready.
    assign ready      = (bus.hready !== 1'b0);
    assign split_hit  = (mas_q != NO_MASTER) && (bus.hresp == RESP_SPLIT);
    assign resp_error = (mas_q != NO_MASTER) && (bus.hresp == RESP_ERROR);

    assign eligible   = bus.hbusreq & ~mask_q;
    assign set_mask   = split_hit ? grant_q : '0;
    assign clr_full   = id_onehot(bus.hsplit);
    assign clr_mask   = clr_full[NUM_MASTERS-1:0];
    // A master split this edge cannot win the hand-off unless released on the same edge.
    assign pick_elig  = eligible & ~(set_mask & ~clr_mask);

    assign owner_req  = |(bus.hbusreq & grant_q);
    assign owner_lock = |(bus.hlock & grant_q);
    assign others     = |(eligible & ~grant_q);
    assign rearb      = !owner_req || ((tenure == TENURE_LAST) && others);

    bus_arbiter_split_pick #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_pick (
        .eligible (pick_elig),
        .start_id (start_id),
        .winner   (pick_id),
        .valid    (pick_valid)
    );

    assign win_full = id_onehot(pick_id);
    assign win_oh   = win_full[NUM_MASTERS-1:0];
    assign win_lock = |(bus.hlock & win_oh);

    always_comb begin
        do_grant  = 1'b0;
        do_idle   = 1'b0;
        do_unlock = 1'b0;
        unique case (state)
            ST_IDLE: begin
                do_grant = ready && pick_valid;
            end
            ST_GRANTED: begin
                if (split_hit || (ready && rearb)) begin
                    do_grant = pick_valid;
                    do_idle  = !pick_valid;
                end
            end
            ST_LOCKED: begin
                if (split_hit) begin
                    do_grant = pick_valid;
                    do_idle  = !pick_valid;
                end else if (resp_error) begin
                    do_unlock = 1'b1;
                end else if (ready && (!owner_lock || !owner_req)) begin
                    if (rearb) begin
                        do_grant = pick_valid;
                        do_idle  = !pick_valid;
                    end else begin
                        do_unlock = 1'b1;
                    end
                end
            end
            default: begin
                do_idle = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            grant_q <= '0;
            mas_q   <= NO_MASTER;
            mlock_q <= 1'b0;
            mask_q  <= '0;
            tenure  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr  <= ID_W'(1);
`endif
        end else begin
            // Clear beats set when the same master is split and released together.
            mask_q <= (mask_q | set_mask) & ~clr_mask;
            if (state != ST_IDLE && tenure != TENURE_LAST) tenure <= tenure + 1'b1;
            if (do_grant) begin
                grant_q <= win_oh;
                mas_q   <= pick_id;
                mlock_q <= win_lock;
                state   <= win_lock ? ST_LOCKED : ST_GRANTED;
                tenure  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                rr_ptr  <= (pick_id == ID_W'(NUM_MASTERS)) ? ID_W'(1) : pick_id + 1'b1;
`endif
            end else if (do_idle) begin
                grant_q <= '0;
                mas_q   <= NO_MASTER;
                mlock_q <= 1'b0;
                state   <= ST_IDLE;
            end else if (do_unlock) begin
                mlock_q <= 1'b0;
                state   <= ST_GRANTED;
            end
        end
    end

    assign bus.hgrant     = grant_q;
    assign bus.hmas       = mas_q;
    assign bus.mlock      = mlock_q;
    assign bus.split_mask = mask_q;
    assign state_dbg      = state;

endmodule

// File: tb/tb_bus_arbiter_split.sv
// Scenario bench for bus_arbiter_split: table-driven steps, expected bus outputs queued per step.
module tb_bus_arbiter_split;
    import bus_arbiter_split_pkg::*;

    localparam int W = 9;

    typedef struct packed {
        logic [2:0] req;
        logic [2:0] lock;
        logic       rdy;
        logic [1:0] resp;
        logic [1:0] split;
        logic [1:0] mas;
        logic       ml;
        logic [2:0] mask;
    } step_t;

    logic       CLK = 1'b0;
    logic       RST;
    arb_state_e state_dbg;
    int         checks = 0;
    int         errors = 0;
    logic [W-1:0] exp_q[$];

    bus_arbiter_split_if #(.NUM_MASTERS(3)) bus ();

    bus_arbiter_split #(
        .NUM_MASTERS (3),
        .MAX_TENURE  (16)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    function automatic step_t mk(input logic [2:0] req, input logic [2:0] lock, input logic rdy,
                                 input logic [1:0] resp, input logic [1:0] split,
                                 input int mas, input logic ml, input logic [2:0] mask);
        step_t s;
        s.req = req; s.lock = lock; s.rdy = rdy; s.resp = resp; s.split = split;
        s.mas = 2'(mas); s.ml = ml; s.mask = mask;
        return s;
    endfunction

    function automatic logic [W-1:0] expv(input int mas, input logic ml, input logic [2:0] mask);
        logic [2:0] g;
        g = (mas == 0) ? 3'b000 : 3'(1 << (mas - 1));
        return {g, 2'(mas), ml, mask};
    endfunction

    function automatic logic [W-1:0] obs();
        return {bus.hgrant, bus.hmas, bus.mlock, bus.split_mask};
    endfunction

    task automatic drive(input step_t s);
        bus.hbusreq = s.req;
        bus.hlock   = s.lock;
        bus.hready  = s.rdy;
        bus.hresp   = s.resp;
        bus.hsplit  = s.split;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        drive(mk(3'b000, 3'b000, 1'b1, RESP_OKAY, 2'd0, 0, 1'b0, 3'b000));
        RST = 1'b1;
        #2;
        RST = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [W-1:0] got, exp;
        drive(mk(3'b000, 3'b000, 1'b1, RESP_OKAY, 2'd0, 0, 1'b0, 3'b000));
        RST = 1'b1;
        exp_q.push_back(expv(0, 1'b0, 3'b000));
        tick();
        got = obs(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_outputs got %h expected %h", got, exp); end
        checks++;
        if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d expected %0d", state_dbg, ST_IDLE); end
        RST = 1'b0;
    endtask

    task automatic test_basic_grant();
        step_t tbl[$];
        logic [W-1:0] got, exp;
        apply_reset();
        tbl.push_back(mk(3'b010, 3'b000, 1'b1, RESP_OKAY, 2'd0, 2, 1'b0, 3'b000));
        tbl.push_back(mk(3'b000, 3'b000, 1'b1, RESP_OKAY, 2'd0, 0, 1'b0, 3'b000));
        foreach (tbl[i]) begin
            drive(tbl[i]); exp_q.push_back(expv(int'(tbl[i].mas), tbl[i].ml, tbl[i].mask)); tick();
            got = obs(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL basic_grant step %0d got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_split();
        step_t tbl[$];
        logic [W-1:0] got, exp;
        apply_reset();
        tbl.push_back(mk(3'b001, 3'b000, 1'b1, RESP_OKAY,  2'd0, 1, 1'b0, 3'b000));
        tbl.push_back(mk(3'b101, 3'b000, 1'b1, RESP_SPLIT, 2'd0, 3, 1'b0, 3'b001));
        tbl.push_back(mk(3'b101, 3'b000, 1'b1, RESP_OKAY,  2'd0, 3, 1'b0, 3'b001));
        tbl.push_back(mk(3'b101, 3'b000, 1'b1, RESP_OKAY,  2'd1, 3, 1'b0, 3'b000));
        tbl.push_back(mk(3'b001, 3'b000, 1'b1, RESP_OKAY,  2'd0, 1, 1'b0, 3'b000));
        tbl.push_back(mk(3'b000, 3'b000, 1'b1, RESP_OKAY,  2'd0, 0, 1'b0, 3'b000));
        foreach (tbl[i]) begin
            drive(tbl[i]); exp_q.push_back(expv(int'(tbl[i].mas), tbl[i].ml, tbl[i].mask)); tick();
            got = obs(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL split step %0d got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_locked();
        step_t tbl[$];
        logic [W-1:0] got, exp;
        apply_reset();
        tbl.push_back(mk(3'b010, 3'b010, 1'b1, RESP_OKAY, 2'd0, 2, 1'b1, 3'b000));
        for (int c = 0; c < 40; c++)
            tbl.push_back(mk(3'b011, 3'b010, 1'b1, RESP_OKAY, 2'd0, 2, 1'b1, 3'b000));
        tbl.push_back(mk(3'b001, 3'b000, 1'b1, RESP_OKAY, 2'd0, 1, 1'b0, 3'b000));
        tbl.push_back(mk(3'b000, 3'b000, 1'b1, RESP_OKAY, 2'd0, 0, 1'b0, 3'b000));
        foreach (tbl[i]) begin
            drive(tbl[i]); exp_q.push_back(expv(int'(tbl[i].mas), tbl[i].ml, tbl[i].mask)); tick();
            got = obs(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL locked step %0d got %h expected %h", i, got, exp); end
            if (i == 0) begin
                checks++;
                if (state_dbg !== ST_LOCKED) begin errors++; $display("FAIL locked_state got %0d expected %0d", state_dbg, ST_LOCKED); end
            end
        end
    endtask

    task automatic test_error_retry();
        step_t tbl[$];
        logic [W-1:0] got, exp;
        apply_reset();
        tbl.push_back(mk(3'b010, 3'b010, 1'b1, RESP_OKAY,  2'd0, 2, 1'b1, 3'b000));
        tbl.push_back(mk(3'b011, 3'b010, 1'b1, RESP_RETRY, 2'd0, 2, 1'b1, 3'b000));
        tbl.push_back(mk(3'b011, 3'b010, 1'b1, RESP_ERROR, 2'd0, 2, 1'b0, 3'b000));
        tbl.push_back(mk(3'b011, 3'b010, 1'b1, RESP_RETRY, 2'd0, 2, 1'b0, 3'b000));
        tbl.push_back(mk(3'b000, 3'b000, 1'b1, RESP_OKAY,  2'd0, 0, 1'b0, 3'b000));
        foreach (tbl[i]) begin
            drive(tbl[i]); exp_q.push_back(expv(int'(tbl[i].mas), tbl[i].ml, tbl[i].mask)); tick();
            got = obs(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL error_retry step %0d got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_tenure();
        step_t tbl[$];
        logic [W-1:0] got, exp;
        int own;
        apply_reset();
        for (int c = 0; c <= 64; c++) begin
`ifdef ARB_ROUND_ROBIN_EN
            own = ((c / 16) % 2 == 0) ? 1 : 3;
`else
            own = 1;
`endif
            tbl.push_back(mk(3'b101, 3'b000, 1'b1, RESP_OKAY, 2'd0, own, 1'b0, 3'b000));
        end
        tbl.push_back(mk(3'b000, 3'b000, 1'b1, RESP_OKAY, 2'd0, 0, 1'b0, 3'b000));
        foreach (tbl[i]) begin
            drive(tbl[i]); exp_q.push_back(expv(int'(tbl[i].mas), tbl[i].ml, tbl[i].mask)); tick();
            got = obs(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL tenure step %0d got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_hready_stall();
        step_t tbl[$];
        logic [W-1:0] got, exp;
        apply_reset();
        tbl.push_back(mk(3'b001, 3'b000, 1'b1, RESP_OKAY, 2'd0, 1, 1'b0, 3'b000));
        for (int c = 0; c < 3; c++)
            tbl.push_back(mk(3'b000, 3'b000, 1'b0, RESP_OKAY, 2'd0, 1, 1'b0, 3'b000));
        tbl.push_back(mk(3'b000, 3'b000, 1'b1, RESP_OKAY, 2'd0, 0, 1'b0, 3'b000));
        tbl.push_back(mk(3'b010, 3'b000, 1'b0, RESP_OKAY, 2'd0, 0, 1'b0, 3'b000));
        tbl.push_back(mk(3'b010, 3'b000, 1'b1, RESP_OKAY, 2'd0, 2, 1'b0, 3'b000));
        tbl.push_back(mk(3'b000, 3'b000, 1'b1, RESP_OKAY, 2'd0, 0, 1'b0, 3'b000));
        foreach (tbl[i]) begin
            drive(tbl[i]); exp_q.push_back(expv(int'(tbl[i].mas), tbl[i].ml, tbl[i].mask)); tick();
            got = obs(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL hready_stall step %0d got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_split_release_race();
        step_t tbl[$];
        logic [W-1:0] got, exp;
        apply_reset();
        tbl.push_back(mk(3'b001, 3'b000, 1'b1, RESP_OKAY,  2'd0, 1, 1'b0, 3'b000));
        tbl.push_back(mk(3'b010, 3'b000, 1'b1, RESP_SPLIT, 2'd1, 2, 1'b0, 3'b000));
        tbl.push_back(mk(3'b010, 3'b000, 1'b1, RESP_OKAY,  2'd0, 2, 1'b0, 3'b000));
        foreach (tbl[i]) begin
            drive(tbl[i]); exp_q.push_back(expv(int'(tbl[i].mas), tbl[i].ml, tbl[i].mask)); tick();
            got = obs(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL split_race step %0d got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_all_masked();
        step_t tbl[$];
        logic [W-1:0] got, exp;
        apply_reset();
        tbl.push_back(mk(3'b001, 3'b000, 1'b1, RESP_OKAY,  2'd0, 1, 1'b0, 3'b000));
        tbl.push_back(mk(3'b011, 3'b000, 1'b1, RESP_SPLIT, 2'd0, 2, 1'b0, 3'b001));
        tbl.push_back(mk(3'b010, 3'b000, 1'b1, RESP_SPLIT, 2'd0, 0, 1'b0, 3'b011));
        tbl.push_back(mk(3'b011, 3'b000, 1'b1, RESP_OKAY,  2'd0, 0, 1'b0, 3'b011));
        tbl.push_back(mk(3'b011, 3'b000, 1'b1, RESP_OKAY,  2'd3, 0, 1'b0, 3'b011));
        tbl.push_back(mk(3'b011, 3'b000, 1'b1, RESP_OKAY,  2'd2, 0, 1'b0, 3'b001));
        tbl.push_back(mk(3'b011, 3'b000, 1'b1, RESP_OKAY,  2'd0, 2, 1'b0, 3'b001));
        foreach (tbl[i]) begin
            drive(tbl[i]); exp_q.push_back(expv(int'(tbl[i].mas), tbl[i].ml, tbl[i].mask)); tick();
            got = obs(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL all_masked step %0d got %h expected %h", i, got, exp); end
        end
    endtask

    // Continues from the granted, partly masked state left by test_all_masked.
    task automatic test_reset_mid_tenure();
        logic [W-1:0] got, exp;
        exp_q.push_back(expv(0, 1'b0, 3'b000));
        RST = 1'b1;
        #2;
        got = obs(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL async_reset got %h expected %h", got, exp); end
        checks++;
        if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL async_reset_state got %0d expected %0d", state_dbg, ST_IDLE); end
        RST = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_grant();
        test_split();
        test_locked();
        test_error_retry();
        test_tenure();
        test_hready_stall();
        test_split_release_race();
        test_all_masked();
        test_reset_mid_tenure();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
